// File: rtl/programmable_counter_pkg.sv
// rtl/programmable_counter_pkg.sv - shared types and constants for programmable_counter
// Purpose: mode encodings, FSM state encoding and a small mode decode helper.
// Ports: none (package).
package programmable_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP    = 2'b00;
  localparam mode_t MODE_SAT     = 2'b01;
  localparam mode_t MODE_ONESHOT = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Mode 11 is not a distinct behaviour; it falls back to wrap.
  function automatic logic is_wrap(input mode_t mode);
    return (mode == MODE_WRAP) || (mode == 2'b11);
  endfunction

endpackage

// File: rtl/programmable_counter_if.sv
// rtl/programmable_counter_if.sv - control/status bundle of programmable_counter
// Purpose: groups the counter configuration inputs and its registered outputs.
// Ports (signals):
//   Initial, Limit, Prescale, Enable, Load, Dir, Mode : driven by the master
//   Q, TerminalCount, Done                           : driven by the counter (slave)
interface programmable_counter_if
  import programmable_counter_pkg::*;
#(
  parameter int SIZE          = 16,
  parameter int PRESCALE_SIZE = 8
);

  logic [SIZE-1:0]          Initial;
  logic [SIZE-1:0]          Limit;
  logic [PRESCALE_SIZE-1:0] Prescale;
  logic                     Enable;
  logic                     Load;
  logic                     Dir;
  mode_t                    Mode;
  logic [SIZE-1:0]          Q;
  logic                     TerminalCount;
  logic                     Done;

  modport master (
    output Initial, Limit, Prescale, Enable, Load, Dir, Mode,
    input  Q, TerminalCount, Done
  );

  modport slave (
    input  Initial, Limit, Prescale, Enable, Load, Dir, Mode,
    output Q, TerminalCount, Done
  );

endinterface

// File: rtl/prescale_tick.sv
// rtl/prescale_tick.sv - clock-enable prescaler producing a count tick
// Purpose: counts enabled cycles 0..Prescale and flags a tick on the cycle the
//          count returns to 0.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   Clear        : forces the count to 0 and suppresses the tick
//   Enable       : advances the count when high, freezes it when low
//   Prescale     : tick period minus one, in enabled cycles
//   Tick         : high for the enabled cycle that ends a period
module prescale_tick #(
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Clear,
  input  logic                     Enable,
  input  logic [PRESCALE_SIZE-1:0] Prescale,
  output logic                     Tick
);

  logic [PRESCALE_SIZE-1:0] count;
  logic                     at_end;

  // ">=" so that lowering Prescale below the current count ends the period
  // immediately instead of running the count all the way round.
  assign at_end = (count >= Prescale);
  assign Tick   = Enable && !Clear && at_end;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count <= '0;
    end else if (Enable) begin
      if (at_end) count <= '0;
      else        count <= count + PRESCALE_SIZE'(1);
    end
  end

endmodule

// File: rtl/programmable_counter.sv
// rtl/programmable_counter.sv - up/down modulo counter with terminal behaviours
// Purpose: prescaled timer with wrap, saturate and one-shot terminal modes and
//          a registered terminal-count pulse.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   bus (slave)  : Initial, Limit, Prescale, Enable, Load, Dir, Mode in;
//                  Q, TerminalCount, Done out (all registered)
module programmable_counter
  import programmable_counter_pkg::*;
#(
  parameter int SIZE          = 16,
  parameter int PRESCALE_SIZE = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  programmable_counter_if.slave bus
);

  state_t          state_q, state_d;
  logic [SIZE-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            tick;
  logic            clear;
  logic            wrap;
  logic [SIZE-1:0] next_val;
  logic [SIZE-1:0] term_val;
  logic            reach;

  // Prescaler is held at 0 while loading or halted so that the first tick
  // after a restart arrives a full period later.
  assign clear = bus.Load || (state_q == HALT);

  prescale_tick #(
    .PRESCALE_SIZE(PRESCALE_SIZE)
  ) u_prescale (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (clear),
    .Enable  (bus.Enable),
    .Prescale(bus.Prescale),
    .Tick    (tick)
  );

  assign wrap     = is_wrap(bus.Mode);
  assign term_val = bus.Dir ? bus.Limit : '0;

  always_comb begin
    next_val = q_q;
    if (bus.Dir) begin
      if (wrap && (q_q == bus.Limit)) next_val = '0;
      else                            next_val = q_q + SIZE'(1);
    end else begin
      if (wrap && (q_q == '0)) next_val = bus.Limit;
      else                     next_val = q_q - SIZE'(1);
    end
  end

  assign reach = (next_val == term_val);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    if (bus.Load) begin
      q_d     = bus.Initial;
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      tc_d = reach;
      if (bus.Mode == MODE_ONESHOT && reach) begin
        // One-shot never shows the terminal value: it reloads and stops.
        q_d     = bus.Initial;
        state_d = HALT;
      end else begin
        q_d = next_val;
        if (bus.Mode == MODE_SAT && reach) state_d = HALT;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RUN;
      q_q     <= bus.Initial;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.Q             = q_q;
  assign bus.TerminalCount = tc_q;
  assign bus.Done          = (state_q == HALT);

endmodule
